// File: rtl/emif_axi_slice_pkg.sv
// -----------------------------------------------------------------------------
// emif_axi_slice_pkg
// Shared definitions for the AXI4 register slice: payload widths of the five
// channels, the buffer-depth legality check and the outstanding-counter width.
// -----------------------------------------------------------------------------
package emif_axi_slice_pkg;

  localparam int CNT_W = 8;

  // AW/AR payload: addr, burst, id, len, lock, qos, size, user, prot
  function automatic int aw_width(input int addr_w, input int id_w, input int user_w);
    return addr_w + 2 + id_w + 8 + 1 + 4 + 3 + user_w + 3;
  endfunction

  function automatic int ar_width(input int addr_w, input int id_w, input int user_w);
    return aw_width(addr_w, id_w, user_w);
  endfunction

  // W payload: user, data, strb, last
  function automatic int w_width(input int data_w, input int user_w);
    return user_w + data_w + data_w / 8 + 1;
  endfunction

  // R payload: user, id, last, resp, data
  function automatic int r_width(input int data_w, input int id_w, input int user_w);
    return user_w + id_w + 1 + 2 + data_w;
  endfunction

  // B payload: id, resp
  function automatic int b_width(input int id_w);
    return id_w + 2;
  endfunction

  // 0 selects pass-through; otherwise a power of two from 2 to 32.
  function automatic bit depth_ok(input int d);
    return (d == 0) || (d >= 2 && d <= 32 && (d & (d - 1)) == 0);
  endfunction

  function automatic bit out_ok(input int n);
    return n >= 1 && n <= 255;
  endfunction

endpackage

// File: rtl/emif_axi_slice_if.sv
// -----------------------------------------------------------------------------
// emif_axi_slice_if
// Five-channel AXI4 bundle. 'master' drives AW/W/AR and the R/B readies;
// 'slave' is the mirror image.
// -----------------------------------------------------------------------------
interface emif_axi_slice_if #(
  parameter int ADDR_WIDTH      = 33,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_W_WIDTH      = 7,
  parameter int ID_R_WIDTH      = 7,
  parameter int USER_REQ_WIDTH  = 4,
  parameter int USER_DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]      awaddr;
  logic [1:0]                 awburst;
  logic [ID_W_WIDTH-1:0]      awid;
  logic [7:0]                 awlen;
  logic                       awlock;
  logic [3:0]                 awqos;
  logic [2:0]                 awsize;
  logic [USER_REQ_WIDTH-1:0]  awuser;
  logic [2:0]                 awprot;
  logic                       awvalid, awready;

  logic [ADDR_WIDTH-1:0]      araddr;
  logic [1:0]                 arburst;
  logic [ID_R_WIDTH-1:0]      arid;
  logic [7:0]                 arlen;
  logic                       arlock;
  logic [3:0]                 arqos;
  logic [2:0]                 arsize;
  logic [USER_REQ_WIDTH-1:0]  aruser;
  logic [2:0]                 arprot;
  logic                       arvalid, arready;

  logic [USER_DATA_WIDTH-1:0] wuser;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [DATA_WIDTH/8-1:0]    wstrb;
  logic                       wlast, wvalid, wready;

  logic [USER_DATA_WIDTH-1:0] ruser;
  logic [ID_R_WIDTH-1:0]      rid;
  logic                       rlast;
  logic [1:0]                 rresp;
  logic [DATA_WIDTH-1:0]      rdata;
  logic                       rvalid, rready;

  logic [ID_W_WIDTH-1:0]      bid;
  logic [1:0]                 bresp;
  logic                       bvalid, bready;

  modport master (
    output awaddr, awburst, awid, awlen, awlock, awqos, awsize, awuser, awprot, awvalid,
    input  awready,
    output araddr, arburst, arid, arlen, arlock, arqos, arsize, aruser, arprot, arvalid,
    input  arready,
    output wuser, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  ruser, rid, rlast, rresp, rdata, rvalid,
    output rready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awburst, awid, awlen, awlock, awqos, awsize, awuser, awprot, awvalid,
    output awready,
    input  araddr, arburst, arid, arlen, arlock, arqos, arsize, aruser, arprot, arvalid,
    output arready,
    input  wuser, wdata, wstrb, wlast, wvalid,
    output wready,
    output ruser, rid, rlast, rresp, rdata, rvalid,
    input  rready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/emif_axi_slice_fifo.sv
// -----------------------------------------------------------------------------
// emif_axi_slice_fifo
// One channel buffer. P_DEPTH = 0 is a wire-through; P_DEPTH = N is a circular
// FIFO whose readiness depends on occupancy only (a pop at full does not open
// the input in the same cycle).
// Ports: clk_i, rst_ni (async active-low), in_valid_i/in_ready_o/in_data_i,
//        out_valid_o/out_ready_i/out_data_o, empty_o (no beat held).
// -----------------------------------------------------------------------------
module emif_axi_slice_fifo #(
  parameter int P_WIDTH = 8,
  parameter int P_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [P_WIDTH-1:0] in_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [P_WIDTH-1:0] out_data_o,
  output logic               empty_o
);

  if (P_DEPTH == 0) begin : g_pass
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign out_data_o  = in_data_i;
    assign empty_o     = 1'b1;
    wire unused_clk_rst = clk_i ^ rst_ni;
  end else begin : g_fifo
    localparam int PW = $clog2(P_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(P_DEPTH);

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]        count_q, count_d;
    logic               push, pop;

    assign in_ready_o  = count_q < FULL;
    assign out_valid_o = count_q != '0;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign empty_o     = count_q == '0;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Depth is a power of two, so the pointers wrap for free.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // NOTE: storage has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: rtl/emif_axi_slice.sv
// -----------------------------------------------------------------------------
// emif_axi_slice
// AXI4 register slice with a buffer per channel, read/write issue limiting and
// outstanding-burst counters.
// Ports: axi_clk, axi_reset_n (async assert, synchronised release),
//        s_axi (subordinate side), m_axi (manager side),
//        rd_outstanding / wr_outstanding (bursts in flight), idle.
// -----------------------------------------------------------------------------
module emif_axi_slice
  import emif_axi_slice_pkg::*;
#(
  parameter int ADDR_WIDTH      = 33,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_W_WIDTH      = 7,
  parameter int ID_R_WIDTH      = 7,
  parameter int USER_REQ_WIDTH  = 4,
  parameter int USER_DATA_WIDTH = 64,
  parameter int AW_DEPTH        = 2,
  parameter int AR_DEPTH        = 2,
  parameter int W_DEPTH         = 2,
  parameter int R_DEPTH         = 2,
  parameter int B_DEPTH         = 2,
  parameter int MAX_RD_OUT      = 16,
  parameter int MAX_WR_OUT      = 16
) (
  input  logic             axi_clk,
  input  logic             axi_reset_n,
  emif_axi_slice_if.slave  s_axi,
  emif_axi_slice_if.master m_axi,
  output logic [CNT_W-1:0] rd_outstanding,
  output logic [CNT_W-1:0] wr_outstanding,
  output logic             idle
);

  if (!depth_ok(AW_DEPTH) || !depth_ok(AR_DEPTH) || !depth_ok(W_DEPTH) ||
      !depth_ok(R_DEPTH) || !depth_ok(B_DEPTH)) begin : g_bad_depth
    $fatal(1, "emif_axi_slice: illegal buffer depth");
  end
  if (!out_ok(MAX_RD_OUT) || !out_ok(MAX_WR_OUT)) begin : g_bad_out
    $fatal(1, "emif_axi_slice: MAX_*_OUT must be 1..255");
  end

  localparam int AW_W = aw_width(ADDR_WIDTH, ID_W_WIDTH, USER_REQ_WIDTH);
  localparam int AR_W = ar_width(ADDR_WIDTH, ID_R_WIDTH, USER_REQ_WIDTH);
  localparam int W_W  = w_width(DATA_WIDTH, USER_DATA_WIDTH);
  localparam int R_W  = r_width(DATA_WIDTH, ID_R_WIDTH, USER_DATA_WIDTH);
  localparam int B_W  = b_width(ID_W_WIDTH);
  localparam logic [CNT_W-1:0] MAX_RD = CNT_W'(MAX_RD_OUT);
  localparam logic [CNT_W-1:0] MAX_WR = CNT_W'(MAX_WR_OUT);

  // Reset: assertion reaches every flop at once; release walks through two
  // flops, and active_q adds one more edge before any ready can rise.
  logic [1:0] rst_sync_q;
  logic       rst_n_sync, active_q;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) rst_sync_q <= '0;
    else              rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_sync = rst_sync_q[1];

  always_ff @(posedge axi_clk or negedge rst_n_sync) begin
    if (!rst_n_sync) active_q <= 1'b0;
    else             active_q <= 1'b1;
  end

  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic             rd_gate, wr_gate;
  logic             aw_rdy, ar_rdy, w_rdy, r_rdy, b_rdy;
  logic             aw_vld, ar_vld, w_vld, r_vld, b_vld;
  logic             aw_emp, ar_emp, w_emp, r_emp, b_emp;
  logic [AW_W-1:0]  aw_data;
  logic [AR_W-1:0]  ar_data;
  logic [W_W-1:0]   w_data;
  logic [R_W-1:0]   r_data;
  logic [B_W-1:0]   b_data;

  // The counters only rise on their own channel's handshake, so a valid that
  // is already up can never be pulled down by its gate.
  assign rd_gate = rd_cnt_q < MAX_RD;
  assign wr_gate = wr_cnt_q < MAX_WR;

  emif_axi_slice_fifo #(.P_WIDTH(AW_W), .P_DEPTH(AW_DEPTH)) u_aw_fifo (
    .clk_i(axi_clk), .rst_ni(rst_n_sync),
    .in_valid_i(s_axi.awvalid & active_q), .in_ready_o(aw_rdy),
    .in_data_i({s_axi.awaddr, s_axi.awburst, s_axi.awid, s_axi.awlen, s_axi.awlock,
                s_axi.awqos, s_axi.awsize, s_axi.awuser, s_axi.awprot}),
    .out_valid_o(aw_vld), .out_ready_i(m_axi.awready & wr_gate),
    .out_data_o(aw_data), .empty_o(aw_emp));

  emif_axi_slice_fifo #(.P_WIDTH(AR_W), .P_DEPTH(AR_DEPTH)) u_ar_fifo (
    .clk_i(axi_clk), .rst_ni(rst_n_sync),
    .in_valid_i(s_axi.arvalid & active_q), .in_ready_o(ar_rdy),
    .in_data_i({s_axi.araddr, s_axi.arburst, s_axi.arid, s_axi.arlen, s_axi.arlock,
                s_axi.arqos, s_axi.arsize, s_axi.aruser, s_axi.arprot}),
    .out_valid_o(ar_vld), .out_ready_i(m_axi.arready & rd_gate),
    .out_data_o(ar_data), .empty_o(ar_emp));

  emif_axi_slice_fifo #(.P_WIDTH(W_W), .P_DEPTH(W_DEPTH)) u_w_fifo (
    .clk_i(axi_clk), .rst_ni(rst_n_sync),
    .in_valid_i(s_axi.wvalid & active_q), .in_ready_o(w_rdy),
    .in_data_i({s_axi.wuser, s_axi.wdata, s_axi.wstrb, s_axi.wlast}),
    .out_valid_o(w_vld), .out_ready_i(m_axi.wready),
    .out_data_o(w_data), .empty_o(w_emp));

  emif_axi_slice_fifo #(.P_WIDTH(R_W), .P_DEPTH(R_DEPTH)) u_r_fifo (
    .clk_i(axi_clk), .rst_ni(rst_n_sync),
    .in_valid_i(m_axi.rvalid & active_q), .in_ready_o(r_rdy),
    .in_data_i({m_axi.ruser, m_axi.rid, m_axi.rlast, m_axi.rresp, m_axi.rdata}),
    .out_valid_o(r_vld), .out_ready_i(s_axi.rready),
    .out_data_o(r_data), .empty_o(r_emp));

  emif_axi_slice_fifo #(.P_WIDTH(B_W), .P_DEPTH(B_DEPTH)) u_b_fifo (
    .clk_i(axi_clk), .rst_ni(rst_n_sync),
    .in_valid_i(m_axi.bvalid & active_q), .in_ready_o(b_rdy),
    .in_data_i({m_axi.bid, m_axi.bresp}),
    .out_valid_o(b_vld), .out_ready_i(s_axi.bready),
    .out_data_o(b_data), .empty_o(b_emp));

  assign s_axi.awready = aw_rdy & active_q;
  assign s_axi.arready = ar_rdy & active_q;
  assign s_axi.wready  = w_rdy & active_q;
  assign m_axi.rready  = r_rdy & active_q;
  assign m_axi.bready  = b_rdy & active_q;

  // active_q also masks pass-through valids while reset is held.
  assign m_axi.awvalid = aw_vld & wr_gate & active_q;
  assign m_axi.arvalid = ar_vld & rd_gate & active_q;
  assign m_axi.wvalid  = w_vld & active_q;
  assign s_axi.rvalid  = r_vld & active_q;
  assign s_axi.bvalid  = b_vld & active_q;

  assign {m_axi.awaddr, m_axi.awburst, m_axi.awid, m_axi.awlen, m_axi.awlock,
          m_axi.awqos, m_axi.awsize, m_axi.awuser, m_axi.awprot} = aw_data;
  assign {m_axi.araddr, m_axi.arburst, m_axi.arid, m_axi.arlen, m_axi.arlock,
          m_axi.arqos, m_axi.arsize, m_axi.aruser, m_axi.arprot} = ar_data;
  assign {m_axi.wuser, m_axi.wdata, m_axi.wstrb, m_axi.wlast} = w_data;
  assign {s_axi.ruser, s_axi.rid, s_axi.rlast, s_axi.rresp, s_axi.rdata} = r_data;
  assign {s_axi.bid, s_axi.bresp} = b_data;

  logic rd_inc, rd_dec, wr_inc, wr_dec, idle_q;
  assign rd_inc = m_axi.arvalid & m_axi.arready;
  assign rd_dec = m_axi.rvalid & m_axi.rready & m_axi.rlast;
  assign wr_inc = m_axi.awvalid & m_axi.awready;
  assign wr_dec = m_axi.bvalid & m_axi.bready;

  // A decrement at zero is a protocol error upstream and is dropped.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_inc && !rd_dec)                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
    else if (!rd_inc && rd_dec && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - CNT_W'(1);
    if (wr_inc && !wr_dec)                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
    else if (!wr_inc && wr_dec && wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge axi_clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      idle_q   <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      idle_q   <= aw_emp & ar_emp & w_emp & r_emp & b_emp &
                  (rd_cnt_q == '0) & (wr_cnt_q == '0);
    end
  end

  assign rd_outstanding = rd_cnt_q;
  assign wr_outstanding = wr_cnt_q;
  assign idle           = idle_q;

endmodule

// File: tb/tb_emif_axi_slice.sv
// -----------------------------------------------------------------------------
// tb_emif_axi_slice
// Self-checking bench: W_DEPTH=4, AR_DEPTH=0, MAX_RD_OUT=2. Inputs change on
// the falling edge and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_emif_axi_slice;

  localparam int AW = 16, DW = 32, IDW = 4, IDR = 4, URW = 2, UDW = 2;

  logic axi_clk = 1'b0;
  logic axi_reset_n = 1'b0;
  always #5 axi_clk = ~axi_clk;

  emif_axi_slice_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_W_WIDTH(IDW), .ID_R_WIDTH(IDR),
                      .USER_REQ_WIDTH(URW), .USER_DATA_WIDTH(UDW)) s_if ();
  emif_axi_slice_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_W_WIDTH(IDW), .ID_R_WIDTH(IDR),
                      .USER_REQ_WIDTH(URW), .USER_DATA_WIDTH(UDW)) m_if ();

  logic [7:0] rd_outstanding, wr_outstanding;
  logic       idle;

  emif_axi_slice #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_W_WIDTH(IDW), .ID_R_WIDTH(IDR),
    .USER_REQ_WIDTH(URW), .USER_DATA_WIDTH(UDW),
    .AW_DEPTH(2), .AR_DEPTH(0), .W_DEPTH(4), .R_DEPTH(2), .B_DEPTH(2),
    .MAX_RD_OUT(2), .MAX_WR_OUT(16)
  ) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
    .s_axi(s_if.slave), .m_axi(m_if.master),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding), .idle(idle)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic sample();
    @(negedge axi_clk);
    #1;
  endtask

  // One W-channel cycle: inputs applied, then state-derived outputs expected.
  typedef struct {
    logic        sv;      // s_axi_wvalid
    logic [31:0] d;       // s_axi_wdata
    logic        mr;      // m_axi_wready
    logic        exp_sr;  // s_axi_wready
    logic        exp_mv;  // m_axi_wvalid
    logic [31:0] exp_md;  // m_axi_wdata (checked only when exp_mv)
  } w_vec_t;

  w_vec_t wv [21];

  task automatic release_reset();
    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      sample();
      check($sformatf("rst_wready_e%0d", k), 64'(s_if.wready), 64'(k >= 3));
      check($sformatf("rst_awready_e%0d", k), 64'(s_if.awready), 64'(k >= 3));
      check($sformatf("rst_idle_e%0d", k), 64'(idle), 64'(k >= 3));
      check($sformatf("rst_mwvalid_e%0d", k), 64'(m_if.wvalid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    // A beats stream with wready high; B beats fill the 4-deep FIFO, then drain.
    wv[0]  = '{1'b1, 32'hA000_0000, 1'b1, 1'b1, 1'b0, 32'h0};
    wv[1]  = '{1'b1, 32'hA000_0001, 1'b1, 1'b1, 1'b1, 32'hA000_0000};
    wv[2]  = '{1'b1, 32'hA000_0002, 1'b1, 1'b1, 1'b1, 32'hA000_0001};
    wv[3]  = '{1'b1, 32'hA000_0003, 1'b1, 1'b1, 1'b1, 32'hA000_0002};
    wv[4]  = '{1'b1, 32'hA000_0004, 1'b1, 1'b1, 1'b1, 32'hA000_0003};
    wv[5]  = '{1'b1, 32'hA000_0005, 1'b1, 1'b1, 1'b1, 32'hA000_0004};
    wv[6]  = '{1'b1, 32'hA000_0006, 1'b1, 1'b1, 1'b1, 32'hA000_0005};
    wv[7]  = '{1'b1, 32'hA000_0007, 1'b1, 1'b1, 1'b1, 32'hA000_0006};
    wv[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hA000_0007};
    wv[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0};
    wv[10] = '{1'b1, 32'hB000_0000, 1'b0, 1'b1, 1'b0, 32'h0};
    wv[11] = '{1'b1, 32'hB000_0001, 1'b0, 1'b1, 1'b1, 32'hB000_0000};
    wv[12] = '{1'b1, 32'hB000_0002, 1'b0, 1'b1, 1'b1, 32'hB000_0000};
    wv[13] = '{1'b1, 32'hB000_0003, 1'b0, 1'b1, 1'b1, 32'hB000_0000};
    wv[14] = '{1'b1, 32'hB000_0004, 1'b0, 1'b0, 1'b1, 32'hB000_0000};
    wv[15] = '{1'b1, 32'hB000_0004, 1'b1, 1'b0, 1'b1, 32'hB000_0000};
    wv[16] = '{1'b1, 32'hB000_0004, 1'b1, 1'b1, 1'b1, 32'hB000_0001};
    wv[17] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hB000_0002};
    wv[18] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hB000_0003};
    wv[19] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hB000_0004};
    wv[20] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0};

    s_if.awaddr = '0; s_if.awburst = 2'b01; s_if.awid = '0; s_if.awlen = '0;
    s_if.awlock = 1'b0; s_if.awqos = '0; s_if.awsize = 3'd2; s_if.awuser = '0;
    s_if.awprot = '0; s_if.awvalid = 1'b0;
    s_if.araddr = '0; s_if.arburst = 2'b01; s_if.arid = '0; s_if.arlen = '0;
    s_if.arlock = 1'b0; s_if.arqos = '0; s_if.arsize = 3'd2; s_if.aruser = '0;
    s_if.arprot = '0; s_if.arvalid = 1'b0;
    s_if.wuser = 2'b01; s_if.wdata = '0; s_if.wstrb = 4'hF; s_if.wlast = 1'b1;
    s_if.wvalid = 1'b0; s_if.rready = 1'b1; s_if.bready = 1'b1;
    m_if.awready = 1'b1; m_if.arready = 1'b1; m_if.wready = 1'b1;
    m_if.ruser = '0; m_if.rid = '0; m_if.rlast = 1'b0; m_if.rresp = '0;
    m_if.rdata = '0; m_if.rvalid = 1'b0;
    m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 1'b0;

    // Reset state
    sample();
    check("reset_wready", 64'(s_if.wready), 64'd0);
    check("reset_arready", 64'(s_if.arready), 64'd0);
    check("reset_rready", 64'(m_if.rready), 64'd0);
    check("reset_idle", 64'(idle), 64'd0);
    check("reset_rd_out", 64'(rd_outstanding), 64'd0);
    release_reset();

    // W channel table
    for (int i = 0; i < 21; i++) begin
      @(negedge axi_clk);
      s_if.wvalid = wv[i].sv;
      s_if.wdata  = wv[i].d;
      m_if.wready = wv[i].mr;
      #1;
      check($sformatf("w%0d_s_wready", i), 64'(s_if.wready), 64'(wv[i].exp_sr));
      check($sformatf("w%0d_m_wvalid", i), 64'(m_if.wvalid), 64'(wv[i].exp_mv));
      if (wv[i].exp_mv) begin
        check($sformatf("w%0d_m_wdata", i), 64'(m_if.wdata), 64'(wv[i].exp_md));
        check($sformatf("w%0d_m_wside", i), 64'({m_if.wuser, m_if.wstrb, m_if.wlast}),
              64'({2'b01, 4'hF, 1'b1}));
      end
    end
    sample();
    check("w_idle", 64'(idle), 64'd1);

    // AR pass-through, issue limit and rd_outstanding
    @(negedge axi_clk);
    s_if.arvalid = 1'b1; s_if.araddr = 16'h0100; s_if.arid = 4'h1;
    #1;
    check("ar0_m_araddr", 64'(m_if.araddr), 64'h0100);
    check("ar0_m_arid", 64'(m_if.arid), 64'h1);
    check("ar0_m_arvalid", 64'(m_if.arvalid), 64'd1);
    check("ar0_s_arready", 64'(s_if.arready), 64'd1);
    m_if.arready = 1'b0;
    #1;
    check("ar0_arready_follows", 64'(s_if.arready), 64'd0);
    m_if.arready = 1'b1;
    @(negedge axi_clk);
    s_if.araddr = 16'h0200;
    #1;
    check("ar1_rd_out", 64'(rd_outstanding), 64'd1);
    check("ar1_m_arvalid", 64'(m_if.arvalid), 64'd1);
    @(negedge axi_clk);
    s_if.araddr = 16'h0300;
    #1;
    check("ar2_rd_out", 64'(rd_outstanding), 64'd2);
    check("ar2_m_arvalid_gated", 64'(m_if.arvalid), 64'd0);
    @(negedge axi_clk);
    m_if.rvalid = 1'b1; m_if.rlast = 1'b1; m_if.rid = 4'h1; m_if.rdata = 32'hDEAD_0001;
    m_if.rresp = 2'b10; m_if.ruser = 2'b11;
    #1;
    check("ar3_still_gated", 64'(m_if.arvalid), 64'd0);
    check("ar3_m_rready", 64'(m_if.rready), 64'd1);
    @(negedge axi_clk);
    m_if.rvalid = 1'b0;
    #1;
    check("ar4_rd_out", 64'(rd_outstanding), 64'd1);
    check("ar4_m_arvalid", 64'(m_if.arvalid), 64'd1);
    check("ar4_m_araddr", 64'(m_if.araddr), 64'h0300);
    check("r_s_rvalid", 64'(s_if.rvalid), 64'd1);
    check("r_s_rpayload", 64'({s_if.ruser, s_if.rid, s_if.rlast, s_if.rresp, s_if.rdata}),
          64'({2'b11, 4'h1, 1'b1, 2'b10, 32'hDEAD_0001}));
    @(negedge axi_clk);
    s_if.arvalid = 1'b0;
    m_if.rvalid = 1'b1; m_if.rlast = 1'b0;   // non-last beat must not decrement
    #1;
    check("ar5_rd_out", 64'(rd_outstanding), 64'd2);
    @(negedge axi_clk);
    m_if.rlast = 1'b1;
    #1;
    check("ar6_rd_out_nonlast", 64'(rd_outstanding), 64'd2);
    @(negedge axi_clk);
    s_if.arvalid = 1'b1; s_if.araddr = 16'h0400;   // AR and RLAST together
    #1;
    check("ar7_rd_out", 64'(rd_outstanding), 64'd1);
    check("ar7_m_arvalid", 64'(m_if.arvalid), 64'd1);
    @(negedge axi_clk);
    s_if.arvalid = 1'b0;
    #1;
    check("ar8_rd_out_same_cycle", 64'(rd_outstanding), 64'd1);
    @(negedge axi_clk);   // RLAST at zero: ignored
    #1;
    check("ar9_rd_out", 64'(rd_outstanding), 64'd0);
    @(negedge axi_clk);
    m_if.rvalid = 1'b0;
    #1;
    check("ar10_rd_underflow", 64'(rd_outstanding), 64'd0);

    // AW / B and wr_outstanding
    @(negedge axi_clk);
    s_if.awvalid = 1'b1; s_if.awaddr = 16'h0040; s_if.awid = 4'h3; s_if.awlen = 8'h07;
    @(negedge axi_clk);
    s_if.awvalid = 1'b0;
    #1;
    check("aw_m_awvalid", 64'(m_if.awvalid), 64'd1);
    check("aw_m_fields", 64'({m_if.awaddr, m_if.awid, m_if.awlen}), 64'({16'h0040, 4'h3, 8'h07}));
    check("aw_wr_out0", 64'(wr_outstanding), 64'd0);
    @(negedge axi_clk);
    m_if.bvalid = 1'b1; m_if.bid = 4'h3; m_if.bresp = 2'b01;
    #1;
    check("aw_wr_out1", 64'(wr_outstanding), 64'd1);
    check("aw_m_awvalid_done", 64'(m_if.awvalid), 64'd0);
    @(negedge axi_clk);
    m_if.bvalid = 1'b0;
    #1;
    check("b_wr_out0", 64'(wr_outstanding), 64'd0);
    check("b_s_bvalid", 64'(s_if.bvalid), 64'd1);
    check("b_s_payload", 64'({s_if.bid, s_if.bresp}), 64'({4'h3, 2'b01}));
    sample();
    check("b_s_bvalid_done", 64'(s_if.bvalid), 64'd0);
    sample();
    check("final_idle", 64'(idle), 64'd1);

    // Reset with three W beats buffered
    m_if.wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge axi_clk);
      s_if.wvalid = 1'b1; s_if.wdata = 32'hC000_0000 + 32'(i);
    end
    @(negedge axi_clk);
    s_if.wvalid = 1'b0;
    #1;
    check("pre_rst_m_wvalid", 64'(m_if.wvalid), 64'd1);
    check("pre_rst_m_wdata", 64'(m_if.wdata), 64'hC000_0000);
    #2;
    axi_reset_n = 1'b0;
    #1;
    check("mid_rst_m_wvalid", 64'(m_if.wvalid), 64'd0);
    check("mid_rst_s_wready", 64'(s_if.wready), 64'd0);
    check("mid_rst_m_bready", 64'(m_if.bready), 64'd0);
    check("mid_rst_idle", 64'(idle), 64'd0);
    m_if.wready = 1'b1;
    sample();
    release_reset();
    sample();
    check("post_rst_no_stale", 64'(m_if.wvalid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
